// File: rtl/clic_irq_sched.sv
// CLIC interrupt scheduler: arbitrates pending+enabled sources by level and
// presents a one-hot request to the core, holding it until acknowledged.
module clic_irq_sched #(
   parameter int unsigned NumSrc   = 64,
   parameter int unsigned LvlWidth = 8,
   parameter int unsigned IdWidth  = $clog2(NumSrc)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         glb_en_i,
   input  logic [NumSrc-1:0]            ip_i,
   input  logic [NumSrc-1:0]            ie_i,
   input  logic [NumSrc*LvlWidth-1:0]   lvl_i,
   output logic [NumSrc-1:0]            irq_o,
   output logic [LvlWidth-1:0]          irq_level_o,
   input  logic                         irq_ack_i,
   output logic                         claim_valid_o,
   output logic [IdWidth-1:0]           claim_id_o
);

   localparam int unsigned NumLeaf = 1 << IdWidth;

   typedef enum logic [1:0] {
      Idle,
      Req,
      Acked
   } state_e;

   typedef struct packed {
      logic                valid;
      logic [IdWidth-1:0]  id;
      logic [LvlWidth-1:0] lvl;
   } cand_t;

   state_e              state_q, state_d;
   cand_t               cand_q, cand_d;
   logic [NumSrc-1:0]   irq_q, irq_d;
   logic [LvlWidth-1:0] irq_level_q, irq_level_d;
   logic [IdWidth-1:0]  pres_id_q, pres_id_d;
   logic                claim_valid_q, claim_valid_d;
   logic [IdWidth-1:0]  claim_id_q, claim_id_d;

   logic [NumSrc-1:0]   eligible;
   cand_t               tree [2*NumLeaf-1];

   assign eligible = ip_i & ie_i & {NumSrc{glb_en_i}};

   // Max-level tournament tree; the left (lower-index) child wins ties.
   always_comb begin
      tree = '{default: '0};
      for (int unsigned i = 0; i < NumSrc; i++) begin
         tree[NumLeaf-1+i].valid = eligible[i];
         tree[NumLeaf-1+i].id    = IdWidth'(i);
         tree[NumLeaf-1+i].lvl   = lvl_i[i*LvlWidth +: LvlWidth];
      end
      for (int n = int'(NumLeaf) - 2; n >= 0; n--) begin
         if (tree[2*n+2].valid &&
             (!tree[2*n+1].valid || (tree[2*n+2].lvl > tree[2*n+1].lvl))) begin
            tree[n] = tree[2*n+2];
         end else begin
            tree[n] = tree[2*n+1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= Idle;
         cand_q        <= '0;
         irq_q         <= '0;
         irq_level_q   <= '0;
         pres_id_q     <= '0;
         claim_valid_q <= 1'b0;
         claim_id_q    <= '0;
      end else begin
         state_q       <= state_d;
         cand_q        <= cand_d;
         irq_q         <= irq_d;
         irq_level_q   <= irq_level_d;
         pres_id_q     <= pres_id_d;
         claim_valid_q <= claim_valid_d;
         claim_id_q    <= claim_id_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cand_d        = tree[0];
      irq_d         = irq_q;
      irq_level_d   = irq_level_q;
      pres_id_d     = pres_id_q;
      claim_valid_d = 1'b0;
      claim_id_d    = '0;

      unique case (state_q)
         Idle: begin
            if (cand_q.valid) begin
               irq_d       = NumSrc'(1) << cand_q.id;
               irq_level_d = cand_q.lvl;
               pres_id_d   = cand_q.id;
               state_d     = Req;
            end
         end
         Req: begin
            // Ack beats withdrawal and preemption in the same cycle.
            if (irq_ack_i) begin
               irq_d         = '0;
               irq_level_d   = '0;
               claim_valid_d = 1'b1;
               claim_id_d    = pres_id_q;
               state_d       = Acked;
            end else if (!eligible[pres_id_q]) begin
               irq_d       = '0;
               irq_level_d = '0;
               state_d     = Idle;
            end else if (cand_q.valid && (cand_q.lvl > irq_level_q)) begin
               irq_d       = NumSrc'(1) << cand_q.id;
               irq_level_d = cand_q.lvl;
               pres_id_d   = cand_q.id;
            end
         end
         Acked: begin
            // Drop the candidate so the claimed source's stale pending bit is not re-presented.
            cand_d  = '0;
            state_d = Idle;
         end
         default: state_d = Idle;
      endcase
   end

   assign irq_o         = irq_q;
   assign irq_level_o   = irq_level_q;
   assign claim_valid_o = claim_valid_q;
   assign claim_id_o    = claim_id_q;

endmodule
